// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads inst_mem combinationally and buffers {pc, inst}
// pairs in a small FIFO for decode. Optional macro FETCH_MISALIGN_CHK_EN adds misaligned-redirect reporting.
module if_fetch_unit #(
  parameter int                   CPU_WIDTH  = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [CPU_WIDTH-1:0] inst_addr,
  input  logic [CPU_WIDTH-1:0] inst,
  input  logic                 redirect,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 if_valid,
  output logic [CPU_WIDTH-1:0] if_pc,
  output logic [CPU_WIDTH-1:0] if_inst,
  input  logic                 id_ready
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                 exc_misalign,
  output logic [CPU_WIDTH-1:0] exc_pc
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [CPU_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]     r_cnt;
  logic [AW-1:0]        r_rd;
  logic [AW-1:0]        r_wr;
  logic [CPU_WIDTH-1:0] r_pc_mem   [FIFO_DEPTH];
  logic [CPU_WIDTH-1:0] r_inst_mem [FIFO_DEPTH];

  logic w_full;
  logic w_pop;
  logic w_push;

  assign inst_addr = r_pc;
  assign if_valid  = (r_cnt != '0);
  assign if_pc     = r_pc_mem[r_rd];
  assign if_inst   = r_inst_mem[r_rd];

  // Handshake: decode consumes the head when if_valid & id_ready; a full FIFO
  // still accepts a new fetch in a cycle where the head leaves.
  assign w_full = (r_cnt == FULL_CNT);
  assign w_pop  = if_valid & id_ready;
  assign w_push = ~redirect & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_cnt <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
    end else if (redirect) begin
      // Flush drops everything, including the head popped this cycle
      r_pc  <= {redirect_pc[CPU_WIDTH-1:2], 2'b00};
      r_cnt <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr]   <= r_pc;
        r_inst_mem[r_wr] <= inst;
        r_wr             <= r_wr + AW'(1);
        r_pc             <= r_pc + CPU_WIDTH'(4);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic                 r_exc_misalign;
  logic [CPU_WIDTH-1:0] r_exc_pc;
  logic                 w_misalign;

  assign w_misalign   = redirect & (redirect_pc[1:0] != 2'b00);
  assign exc_misalign = r_exc_misalign;
  assign exc_pc       = r_exc_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc_misalign <= 1'b0;
      r_exc_pc       <= '0;
    end else begin
      r_exc_misalign <= w_misalign;
      if (w_misalign) begin
        r_exc_pc <= redirect_pc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference of the fetch stream, directed scenarios then
// randomized ready/redirect/reset traffic; also covers FETCH_MISALIGN_CHK_EN when defined.
module tb_if_fetch_unit;

  localparam int          W   = 32;
  localparam int          D   = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic         clk;
  logic         rst;
  logic [W-1:0] inst_addr;
  logic [W-1:0] inst;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_inst;
  logic         id_ready;
`ifdef FETCH_MISALIGN_CHK_EN
  logic         exc_misalign;
  logic [W-1:0] exc_pc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_unit #(.CPU_WIDTH(W), .RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr   (inst_addr),
    .inst        (inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .id_ready    (id_ready)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .exc_misalign(exc_misalign),
    .exc_pc      (exc_pc)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: each word's content is a fixed scramble of its address
  function automatic logic [W-1:0] mem_f(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb inst = mem_f(inst_addr);

  // Reference model: expected fetch stream as a queue of {pc, inst}
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_pc;
  logic           m_exc;
  logic [W-1:0]   m_exc_pc;
  bit             m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc     = RPC;
      exp_q.delete();
      m_exc    = 1'b0;
      m_exc_pc = '0;
      m_live   = 1'b1;
    end else if (m_live) begin
      if (redirect) begin
        exp_q.delete();
        m_exc = (redirect_pc[1:0] != 2'b00);
        if (m_exc) m_exc_pc = redirect_pc;
        m_pc = {redirect_pc[W-1:2], 2'b00};
      end else begin
        m_exc = 1'b0;
        if (exp_q.size() < D) begin
          exp_q.push_back({m_pc, mem_f(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: compares on the falling edge, consumes on accepted pops
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (m_live) begin
      chk("inst_addr", inst_addr, m_pc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("if_pc", if_pc, e[2*W-1:W]);
        chk("if_inst", if_inst, e[W-1:0]);
        if (id_ready) void'(exp_q.pop_front());
      end
`ifdef FETCH_MISALIGN_CHK_EN
      chk("exc_misalign", {31'd0, exc_misalign}, {31'd0, m_exc});
      chk("exc_pc", exc_pc, m_exc_pc);
`endif
    end
  end

  // Driver: apply inputs just after the rising edge and hold for n cycles
  task automatic drive(input logic r, input logic rdy, input logic rd, input logic [W-1:0] rp,
                       input int n);
    rst         = r;
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rp;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 2);                 // reset
    drive(0, 1, 0, 0, 8);                 // streaming from RESET_PC
    drive(0, 0, 0, 0, 5);                 // stall: FIFO fills, PC holds
    drive(0, 1, 0, 0, 4);
    drive(0, 0, 0, 0, 3);                 // fill, then redirect while full
    drive(0, 0, 1, 32'h0000_0100, 1);
    drive(0, 1, 0, 0, 6);
    drive(0, 1, 1, 32'h0000_0100, 1);     // redirect with same-cycle pop
    drive(0, 1, 0, 0, 5);
    drive(0, 1, 1, 32'h0000_0202, 1);     // misaligned target
    drive(0, 1, 0, 0, 4);
    drive(0, 0, 0, 0, 2);                 // reset mid-stream with entries buffered
    drive(1, 0, 1, 32'h0000_0400, 1);
    drive(0, 1, 0, 0, 4);
    drive(0, 1, 1, 32'hFFFF_FFF8, 1);     // PC wrap-around
    drive(0, 1, 0, 0, 6);
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            $urandom(),
            1);
    end
    drive(0, 1, 0, 0, 4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
